// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory request/response channel between fetch and memory
interface pc_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: next-PC selection, instruction fetch and hold, sticky misaligned-target trap
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  CTL_PcSel,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        advance,
  pc_fetch_if.master  imem,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned_trap,
  output logic [31:0] trap_pc
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, TRAP} stateT;
  stateT       state, nextState;
  logic [31:0] target;
  assign pc_plus4 = pc + 32'd4;
  // Target select (reserved 11 falls back to pc+4), handshake outputs and next state
  always_comb begin
    target = CTL_PcSel == 2'b01 ? pc + imm :
             CTL_PcSel == 2'b10 ? (rs1_data + imm) & ~32'h1 : pc_plus4;
    imem.imem_req_valid = state == REQ;
    imem.imem_req_addr = pc;
    inst_valid = state == HOLD;
    nextState = state;
    case (state)
      REQ:  nextState = imem.imem_req_ready ? WAIT : REQ;
      WAIT: nextState = imem.imem_rsp_valid ? HOLD : WAIT;
      HOLD: nextState = !advance ? HOLD : target[1:0] == 2'b00 ? REQ : TRAP;
      TRAP: nextState = TRAP;
      default: nextState = REQ;
    endcase
  end
  // State, held instruction, PC update on retire and sticky trap capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc <= RESET_PC;
      inst <= NOP;
      misaligned_trap <= 1'b0;
      trap_pc <= 32'h0;
    end else begin
      state <= nextState;
      if (state == WAIT && imem.imem_rsp_valid) inst <= imem.imem_rsp_data;
      if (state == HOLD && advance) begin
        if (target[1:0] == 2'b00) pc <= target;
        else begin
          misaligned_trap <= 1'b1;
          trap_pc <= target;
        end
      end
    end
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage of the single-cycle core. It sits directly downstream of the control unit: it consumes `CTL_PcSel` together with the immediate and rs1 operand, and computes and registers the next PC. It also fetches the next instruction over a valid/ready instruction-memory interface and holds it stable for the datapath until the core retires it. Misaligned jump or branch targets halt fetch and raise a sticky trap.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be 4-byte aligned.

Ports:
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `CTL_PcSel`  in  2: next-PC select from control.
  - `CTL_PCSEL_PCPLUS4` = 2'b00.
  - `CTL_PCSEL_PCPLUSIMM` = 2'b01.
  - `CTL_PCSEL_RPLUSIMM` = 2'b10.
  - 2'b11 is reserved.
- `imm`  in  32: sign-extended immediate of the current instruction.
- `rs1_data`  in  32: rs1 register value; used for JALR.
- `advance`  in  1: datapath retires the held instruction this cycle.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_addr`  out  32: fetch address.
- `imem_req_ready`  in  1: memory accepts the request.
- `imem_rsp_valid`  in  1: fetch data valid.
- `imem_rsp_data`  in  32: fetched instruction word.
- `inst`  out  32: held instruction.
- `inst_valid`  out  1: `inst` and `pc` are valid.
- `pc`  out  32: address of the held instruction.
- `pc_plus4`  out  32: `pc + 4`, used for JAL/JALR writeback.
- `misaligned_trap`  out  1: sticky; target was misaligned.
- `trap_pc`  out  32: the offending target address.

## Operation
- The FSM has four states: REQ, WAIT, HOLD, TRAP.
- **REQ**
  - `imem_req_valid`=1 and `imem_req_addr`=`pc`.
  - On `imem_req_valid & imem_req_ready`, go to WAIT.
  - `imem_rsp_valid` is ignored in REQ, which discards stale responses that arrive after a reset.
- **WAIT**
  - `imem_req_valid`=0.
  - On `imem_rsp_valid`, latch `imem_rsp_data` into `inst` and go to HOLD.
- **HOLD**
  - `inst_valid`=1; `inst` and `pc` are stable.
  - While `advance`=0, stay in HOLD.
  - On `advance`=1, compute the target:
    - 2'b00 or 2'b11: `pc+4`.
    - 2'b01: `pc+imm`.
    - 2'b10: `(rs1_data+imm) & ~32'h1`.
  - If `target[1:0]==0`: `pc`<=target, go to REQ.
  - Otherwise: `misaligned_trap`<=1, `trap_pc`<=target, `pc` unchanged, go to TRAP.
- **TRAP**
  - `imem_req_valid`=0 and `inst_valid`=0.
  - All inputs are ignored; the only exit is `rst`.
- Arithmetic:
  - All adds are 32-bit modulo 2^32. `pc+4` from `32'hFFFF_FFFC` wraps to `32'h0`.
  - `pc_plus4` is combinational from `pc`.
- Request stability: once `imem_req_valid` is asserted, `imem_req_addr` stays constant until accepted.
- At most one request is outstanding at any time.
- `advance` is ignored outside HOLD.
- `CTL_PcSel`, `imm` and `rs1_data` are sampled only in the HOLD cycle where `advance`=1.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - State = REQ.
  - `pc`=`RESET_PC`.
  - `inst`=`32'h0000_0013` (NOP).
  - `inst_valid`=0, `misaligned_trap`=0, `trap_pc`=0.
  - `imem_req_valid`=1 with `imem_req_addr`=`RESET_PC` in that cycle.
- Reset has priority over every other event in every state, including mid-WAIT and TRAP.
- Cycle sequence with a zero-wait memory (ready=1, response one cycle after acceptance):
  - Cycle 0: REQ; request accepted.
  - Cycle 1: WAIT; `rsp_valid`=1.
  - Cycle 2: HOLD; `inst_valid`=1.
  - The new request appears the cycle after `advance` is sampled.
- Fetch throughput is one instruction per 3 cycles minimum.
- If `imem_rsp_valid` is asserted in the same cycle the request is accepted, it is ignored, because the state is still REQ.
- `misaligned_trap` rises the cycle after the offending `advance`.
- `inst_valid` falls the cycle after any `advance` in HOLD.

## Test plan
- **Reset fetch:** hold `rst` 2 cycles, release, `RESET_PC`=`32'h100`, `imem_req_ready`=1 -> `imem_req_addr`=`32'h100` on the first post-reset cycle. Return `imem_rsp_data`=`32'h00500093` the next cycle -> `inst_valid`=1 with `inst`=`32'h00500093` and `pc`=`32'h100` one cycle later.
- **Sequential and backpressure:** `advance` with PcSel=00 at `pc`=`32'h100`. Hold `imem_req_ready`=0 for 3 cycles -> `imem_req_valid` stays 1 with addr stable at `32'h104`, and exactly one request is accepted.
- **Branch/JAL:** PcSel=01, `imm`=`32'hFFFF_FFF8` at `pc`=`32'h104` -> next request addr `32'hFC`.
- **JALR:** PcSel=10, `rs1_data`=`32'h201`, `imm`=`32'h7` -> target `32'h208`, no trap. Then `rs1_data`=`32'h201`, `imm`=`32'h1` -> `trap_pc`=`32'h202`, `misaligned_trap`=1, and no further requests even with `advance` toggling.
- **Wrap and reserved select:** `pc`=`32'hFFFF_FFFC`, PcSel=11 -> next addr `32'h0`. `pc_plus4`=`32'h0` while held.
- **Reset mid-operation:** assert `rst` in WAIT, then drive a stale `imem_rsp_valid` in the first post-reset cycle -> the response is ignored, `inst_valid` stays 0, and a fresh request to `RESET_PC` is issued. Assert `rst` in TRAP -> `misaligned_trap` clears.
